// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select, load-use stall and branch flush for the 5-stage RV32I core.
// Build option: define HAZ_FWD_EN to enable forwarding; otherwise dependents wait in ID.
module fwd_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter bit WB_THRU = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_rd_wren,
  input  logic              i_id_is_load,
  input  logic              i_ex_br_taken,
  output logic [1:0]        o_fwd_a_sel,
  output logic [1:0]        o_fwd_b_sel,
  output logic              o_stall,
  output logic              o_flush_ifid,
  output logic              o_flush_idex
);

  typedef enum logic [1:0] {
    SEL_RF   = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_WB   = 2'b10,
    SEL_NONE = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wren;
    logic              is_load;
  } tag_t;

  typedef struct packed {
    tag_t              tag;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } ex_tag_t;

  ex_tag_t r_ex;
  tag_t    r_mem;
  tag_t    r_wb;

  logic     w_hit_ex;
  logic     w_hit_mem;
  logic     w_hit_wb;
  logic     w_stall_req;
  logic     w_id_advance;
  fwd_sel_e w_fwd_a;
  fwd_sel_e w_fwd_b;
  logic     w_unused;

  // A stage produces register r only if it is real, writes, and r is not x0.
  function automatic logic f_writer(input tag_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.wren && (s.rd == r) && (r != '0);
  endfunction

  function automatic logic f_id_hit(input tag_t s, input logic [REG_AW-1:0] rs1,
                                    input logic [REG_AW-1:0] rs2);
    return f_writer(s, rs1) || f_writer(s, rs2);
  endfunction

`ifdef HAZ_FWD_EN
  // A load in MEM has no data yet; the load-use stall keeps that case from arising.
  function automatic fwd_sel_e f_fwd_sel(input tag_t mem, input tag_t wb,
                                         input logic [REG_AW-1:0] r);
    if (f_writer(mem, r) && !mem.is_load) return SEL_MEM;
    if (f_writer(wb, r))                  return SEL_WB;
    return SEL_RF;
  endfunction
`endif

  assign w_hit_ex  = f_id_hit(r_ex.tag, i_id_rs1, i_id_rs2);
  assign w_hit_mem = f_id_hit(r_mem,    i_id_rs1, i_id_rs2);
  assign w_hit_wb  = f_id_hit(r_wb,     i_id_rs1, i_id_rs2);

  always_comb begin
    // NOTE: every variable gets a default first so no branch can infer a latch.
    w_fwd_a     = SEL_RF;
    w_fwd_b     = SEL_RF;
    w_stall_req = 1'b0;
`ifdef HAZ_FWD_EN
    w_fwd_a     = f_fwd_sel(r_mem, r_wb, r_ex.rs1);
    w_fwd_b     = f_fwd_sel(r_mem, r_wb, r_ex.rs2);
    w_stall_req = i_id_valid && ((r_ex.tag.is_load && w_hit_ex) || (!WB_THRU && w_hit_wb));
`else
    w_stall_req = i_id_valid && (w_hit_ex || w_hit_mem || (!WB_THRU && w_hit_wb));
`endif
  end

  // A taken branch kills the ID instruction, so it must never also hold the front end.
  assign o_stall      = w_stall_req && !i_ex_br_taken;
  assign o_flush_ifid = i_ex_br_taken;
  assign o_flush_idex = i_ex_br_taken;
  assign o_fwd_a_sel  = w_fwd_a;
  assign o_fwd_b_sel  = w_fwd_b;

  assign w_id_advance = i_id_valid && !o_stall && !i_ex_br_taken;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage read its predecessor's old value.
      r_wb  <= r_mem;
      r_mem <= r_ex.tag;
      if (w_id_advance) begin
        r_ex.tag.valid   <= 1'b1;
        r_ex.tag.rd      <= i_id_rd;
        r_ex.tag.wren    <= i_id_rd_wren;
        r_ex.tag.is_load <= i_id_is_load;
        r_ex.rs1         <= i_id_rs1;
        r_ex.rs2         <= i_id_rs2;
      end else begin
        r_ex <= '0;
      end
    end
  end

`ifdef HAZ_FWD_EN
  assign w_unused = r_wb.is_load ^ w_hit_mem;
`else
  assign w_unused = ^{r_wb.is_load, r_ex.rs1, r_ex.rs2};
`endif

endmodule
